// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared constants and stage record for the leading-zero normalizer
package norm_pkg;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int S     = $clog2(WIDTH);
  localparam int SHW   = S + 1;

  // One pipeline slot: the word in flight, the shift bits decided so far,
  // and the sideband tag that rides along untouched.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic [TAG_W-1:0] tag;
  } stage_t;

endpackage

// File: rtl/norm_stage.sv
// rtl/norm_stage.sv - one normalization level: shift left by W when the top W bits are zero
module norm_stage
  import norm_pkg::*;
#(
  parameter int W   = 1,
  parameter int BIT = 0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
  input  stage_t in_stage,
  output stage_t out_stage
);

  stage_t stage_d;
  stage_t stage_q;
  logic   top_zero;

  // Decide this level's shift; hold everything (valid included) while stalled.
  always_comb begin
    top_zero = (in_stage.data[WIDTH-1 -: W] == '0);
    stage_d  = stage_q;
    if (enable) begin
      stage_d = in_stage;
      if (top_zero) begin
        stage_d.data       = in_stage.data << W;
        stage_d.shamt[BIT] = 1'b1;
      end
    end
  end

  // Stage register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_stage = stage_q;

endmodule

// File: rtl/pipelined_normalizer_32.sv
// rtl/pipelined_normalizer_32.sv - pipelined leading-zero normalizer with valid/ready handshake
module pipelined_normalizer_32
  import norm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  stage_t chain [S+1];
  logic   advance;
  logic   last_zero;

  // Global stall: the whole pipe moves only when the output slot is empty or drained.
  assign advance  = ~chain[S].valid | out_ready;
  assign in_ready = advance;

  // A bubble enters stage 0 whenever in_valid is low and the pipe advances.
  assign chain[0] = '{valid: in_valid, data: in_data, shamt: '0, tag: in_tag};

  // Coarsest shift first: 16, 8, 4, 2, 1 for a 32-bit word.
  for (genvar k = 0; k < S; k++) begin : g_stage
    norm_stage #(
      .W   (WIDTH >> (k + 1)),
      .BIT (S - 1 - k)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .enable    (advance),
      .in_stage  (chain[k]),
      .out_stage (chain[k+1])
    );
  end

  // Zero fix-up on the last register: an all-zero word never gets its MSB set,
  // so report the full width as the shift amount.
  always_comb begin
    last_zero = chain[S].valid & ~chain[S].data[WIDTH-1];
    out_valid = chain[S].valid;
    out_zero  = last_zero;
    out_shamt = last_zero ? SHW'(WIDTH) : chain[S].shamt;
    out_data  = chain[S].data;
    out_tag   = chain[S].tag;
  end

endmodule

// File: tb/tb_pipelined_normalizer_32.sv
// tb/tb_pipelined_normalizer_32.sv - randomized bench against a behavioural normalizer model
module tb_pipelined_normalizer_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_shamt;
  logic        out_zero;
  logic [3:0]  out_tag;

  int checks   = 0;
  int failures = 0;

  // Model: five slots of in-flight words, plus what the reset clears.
  bit          m_v [5];
  logic [31:0] m_d [5];
  logic [3:0]  m_t [5];
  bit          m_known       = 0;
  bit          m_after_reset = 0;

  // Literal expectation armed for one particular cycle.
  bit          lit_en = 0;
  string       lit_name;
  logic [31:0] lit_data;
  logic [5:0]  lit_shamt;
  logic        lit_zero;
  logic [3:0]  lit_tag;

  always #5 clk = ~clk;

  pipelined_normalizer_32 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Normalize by repeated single-bit shifting.
  function automatic void ref_norm(input logic [31:0] d, output logic [31:0] nd,
                                   output logic [5:0] sh, output logic z);
    nd = d;
    sh = 6'd0;
    z  = 1'b0;
    if (d == 32'd0) begin
      sh = 6'd32;
      z  = 1'b1;
    end else begin
      while (!nd[31]) begin
        nd = nd << 1;
        sh = sh + 6'd1;
      end
    end
  endfunction

  task automatic set_lit(input string name, input logic [31:0] d, input logic [5:0] sh,
                         input logic z, input logic [3:0] t);
    lit_en    = 1;
    lit_name  = name;
    lit_data  = d;
    lit_shamt = sh;
    lit_zero  = z;
    lit_tag   = t;
  endtask

  // One clock: drive, compare against the model away from the edge, then step the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [3:0] t,
                       input logic ordy, input logic rst);
    logic [31:0] ed;
    logic [5:0]  es;
    logic        ez;
    bit          adv;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    reset     = rst;
    #1;
    if (m_known) begin
      chk("out_valid", out_valid, m_v[4]);
      chk("in_ready", in_ready, !m_v[4] || ordy);
      if (m_v[4]) begin
        ref_norm(m_d[4], ed, es, ez);
        chk("out_data", out_data, ed);
        chk("out_shamt", out_shamt, es);
        chk("out_zero", out_zero, ez);
        chk("out_tag", out_tag, m_t[4]);
      end
      if (m_after_reset) begin
        chk("rst_out_data", out_data, 0);
        chk("rst_out_shamt", out_shamt, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
      end
    end
    if (lit_en) begin
      chk({lit_name, "_valid"}, out_valid, 1);
      chk({lit_name, "_data"}, out_data, lit_data);
      chk({lit_name, "_shamt"}, out_shamt, lit_shamt);
      chk({lit_name, "_zero"}, out_zero, lit_zero);
      chk({lit_name, "_tag"}, out_tag, lit_tag);
      lit_en = 0;
    end
    adv = !m_v[4] || ordy;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_v[i] = 0;
        m_d[i] = '0;
        m_t[i] = '0;
      end
      m_known       = 1;
      m_after_reset = 1;
    end else begin
      m_after_reset = 0;
      if (adv) begin
        for (int i = 4; i > 0; i--) begin
          m_v[i] = m_v[i-1];
          m_d[i] = m_d[i-1];
          m_t[i] = m_t[i-1];
        end
        m_v[0] = v;
        m_d[0] = d;
        m_t[0] = t;
      end
    end
  endtask

  task automatic bubble();
    cycle(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] pd;
    logic [5:0]  ps;
    logic        pz;
    logic        rv;
    logic        rr;
    logic        rs;
    logic [31:0] rd;
    logic [3:0]  rt;

    in_valid  = 0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 0;
    reset     = 1;

    // Pin the model on hand-computed values.
    ref_norm(32'h00000001, pd, ps, pz);
    chk("pin_one_data", pd, 32'h80000000);
    chk("pin_one_shamt", ps, 31);
    ref_norm(32'h00000000, pd, ps, pz);
    chk("pin_zero_shamt", ps, 32);
    chk("pin_zero_flag", pz, 1);
    ref_norm(32'h0000FFFF, pd, ps, pz);
    chk("pin_ffff_data", pd, 32'hFFFF0000);
    chk("pin_ffff_shamt", ps, 16);
    ref_norm(32'h00C00000, pd, ps, pz);
    chk("pin_c0_shamt", ps, 8);
    ref_norm(32'h00000100, pd, ps, pz);
    chk("pin_100_shamt", ps, 23);

    cycle(1'b0, 32'd0, 4'd0, 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 4'd0, 1'b1, 1'b1);

    // Single word, five cycles later.
    cycle(1'b1, 32'h00000001, 4'd3, 1'b1, 1'b0);
    repeat (4) bubble();
    set_lit("one", 32'h80000000, 6'd31, 1'b0, 4'd3);
    bubble();

    // Back-to-back already-normalized and one-off words.
    cycle(1'b1, 32'h80000000, 4'd1, 1'b1, 1'b0);
    cycle(1'b1, 32'h40000000, 4'd2, 1'b1, 1'b0);
    repeat (3) bubble();
    set_lit("msb", 32'h80000000, 6'd0, 1'b0, 4'd1);
    bubble();
    set_lit("msb1", 32'h80000000, 6'd1, 1'b0, 4'd2);
    bubble();

    // All-zero word.
    cycle(1'b1, 32'h00000000, 4'd5, 1'b1, 1'b0);
    repeat (4) bubble();
    set_lit("zero", 32'h00000000, 6'd32, 1'b1, 4'd5);
    bubble();

    // Three-word stream.
    cycle(1'b1, 32'h00010000, 4'd6, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000FFFF, 4'd7, 1'b1, 1'b0);
    cycle(1'b1, 32'h00C00000, 4'd8, 1'b1, 1'b0);
    repeat (2) bubble();
    set_lit("s15", 32'h80000000, 6'd15, 1'b0, 4'd6);
    bubble();
    set_lit("s16", 32'hFFFF0000, 6'd16, 1'b0, 4'd7);
    bubble();
    set_lit("s8", 32'hC0000000, 6'd8, 1'b0, 4'd8);
    bubble();

    // Fill, stall for three cycles, then release.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1 << (i * 6), 4'(i), 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 32'h0000DEAD, 4'd9, 1'b0, 1'b0);
    set_lit("stall0", 32'h80000000, 6'd31, 1'b0, 4'd0);
    repeat (6) bubble();

    // Reset with three words in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h00F00000 >> i, 4'(i + 10), 1'b1, 1'b0);
    cycle(1'b1, 32'h00000005, 4'd1, 1'b1, 1'b1);
    repeat (6) bubble();
    cycle(1'b1, 32'h00000100, 4'd9, 1'b1, 1'b0);
    repeat (4) bubble();
    set_lit("after_rst", 32'h80000000, 6'd23, 1'b0, 4'd9);
    bubble();

    // Randomized traffic with random backpressure and rare resets.
    repeat (3000) begin
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 299) == 0);
      rd = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      rt = 4'($urandom);
      cycle(rv, rd, rt, rr, rs);
    end
    repeat (8) bubble();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
